// File: rtl/sap_ctrl_seq_if.sv
// Control bus between the SAP controller-sequencer and the datapath registers.
// The datapath side (master) supplies the IR opcode and observes the control word.
interface sap_ctrl_seq_if;
  logic [3:0] opcode;
  logic       pc_inc;
  logic       pc_en;
  logic       mar_ld;
  logic       ram_en;
  logic       ir_ld;
  logic       ir_en;
  logic       a_ld;
  logic       a_en;
  logic       b_ld;
  logic       alu_en;
  logic       alu_sub;
  logic       out_ld;
  logic       halt;
  logic [5:0] t_state;
  logic [7:0] instr_count;

  modport master (
    output opcode,
    input  pc_inc, pc_en, mar_ld, ram_en, ir_ld, ir_en, a_ld, a_en,
    input  b_ld, alu_en, alu_sub, out_ld, halt, t_state, instr_count
  );

  modport slave (
    input  opcode,
    output pc_inc, pc_en, mar_ld, ram_en, ir_ld, ir_en, a_ld, a_en,
    output b_ld, alu_en, alu_sub, out_ld, halt, t_state, instr_count
  );
endinterface

// File: rtl/sap_ctrl_seq.sv
// SAP controller-sequencer: 6-state one-hot ring (T1..T6) with a control word
// decoded from the ring state and IR opcode; latches HLT and counts instructions.
module sap_ctrl_seq #(
  parameter logic [3:0] OPC_LDA = 4'h0,
  parameter logic [3:0] OPC_ADD = 4'h1,
  parameter logic [3:0] OPC_SUB = 4'h2,
  parameter logic [3:0] OPC_OUT = 4'hE,
  parameter logic [3:0] OPC_HLT = 4'hF
) (
  input  logic           clk,
  input  logic           clr_n,
  sap_ctrl_seq_if.slave  bus
);

  localparam int unsigned T_W   = 6;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [T_W-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  // Kept as a plain vector so a corrupted (non one-hot) value is representable.
  logic [T_W-1:0]   state_q;
  logic             halted_q;
  logic [CNT_W-1:0] count_q;

  logic is_hlt_c;
  assign is_hlt_c = (bus.opcode == OPC_HLT);

  // Ring advance, halt latch and completed-instruction counter.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= T1;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      case (state_q)
        T1: state_q <= T2;
        T2: state_q <= T3;
        T3: state_q <= T4;
        T4: begin
          if (!halted_q && !is_hlt_c) begin
            state_q <= T5;
          end
        end
        T5: state_q <= T6;
        T6: begin
          state_q <= T1;
          count_q <= count_q + CNT_W'(1);
        end
        default: state_q <= T1;
      endcase
      if (state_q == T4 && is_hlt_c) begin
        halted_q <= 1'b1;
      end
    end
  end

  logic pc_inc_c, pc_en_c, mar_ld_c, ram_en_c, ir_ld_c, ir_en_c;
  logic a_ld_c, a_en_c, b_ld_c, alu_en_c, alu_sub_c, out_ld_c, halt_c;
  logic active_c;

  // Decoding is suppressed in reset and once halted so no ld pulse can escape.
  assign active_c = clr_n && !halted_q;

  always_comb begin
    pc_inc_c  = 1'b0;
    pc_en_c   = 1'b0;
    mar_ld_c  = 1'b0;
    ram_en_c  = 1'b0;
    ir_ld_c   = 1'b0;
    ir_en_c   = 1'b0;
    a_ld_c    = 1'b0;
    a_en_c    = 1'b0;
    b_ld_c    = 1'b0;
    alu_en_c  = 1'b0;
    alu_sub_c = 1'b0;
    out_ld_c  = 1'b0;
    if (active_c) begin
      case (state_q)
        T1: begin
          pc_en_c  = 1'b1;
          mar_ld_c = 1'b1;
        end
        T2: pc_inc_c = 1'b1;
        T3: begin
          ram_en_c = 1'b1;
          ir_ld_c  = 1'b1;
        end
        T4: begin
          if (bus.opcode == OPC_LDA || bus.opcode == OPC_ADD || bus.opcode == OPC_SUB) begin
            ir_en_c  = 1'b1;
            mar_ld_c = 1'b1;
          end else if (bus.opcode == OPC_OUT) begin
            a_en_c   = 1'b1;
            out_ld_c = 1'b1;
          end
        end
        T5: begin
          if (bus.opcode == OPC_LDA) begin
            ram_en_c = 1'b1;
            a_ld_c   = 1'b1;
          end else if (bus.opcode == OPC_ADD || bus.opcode == OPC_SUB) begin
            ram_en_c  = 1'b1;
            b_ld_c    = 1'b1;
            alu_sub_c = (bus.opcode == OPC_SUB);
          end
        end
        T6: begin
          if (bus.opcode == OPC_ADD || bus.opcode == OPC_SUB) begin
            alu_en_c  = 1'b1;
            a_ld_c    = 1'b1;
            alu_sub_c = (bus.opcode == OPC_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  // halt is visible during T4 of HLT, one cycle before the flag is latched.
  assign halt_c = clr_n && (halted_q || (state_q == T4 && is_hlt_c));

  assign bus.pc_inc      = pc_inc_c;
  assign bus.pc_en       = pc_en_c;
  assign bus.mar_ld      = mar_ld_c;
  assign bus.ram_en      = ram_en_c;
  assign bus.ir_ld       = ir_ld_c;
  assign bus.ir_en       = ir_en_c;
  assign bus.a_ld        = a_ld_c;
  assign bus.a_en        = a_en_c;
  assign bus.b_ld        = b_ld_c;
  assign bus.alu_en      = alu_en_c;
  assign bus.alu_sub     = alu_sub_c;
  assign bus.out_ld      = out_ld_c;
  assign bus.halt        = halt_c;
  assign bus.t_state     = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// Scoreboard bench for sap_ctrl_seq: the driver queues the expected control word
// for each cycle, a negedge monitor pops and compares it and checks bus exclusivity.
module tb_sap_ctrl_seq;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  sap_ctrl_seq_if bus ();

  sap_ctrl_seq dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // Control word packing: {pc_inc,pc_en,mar_ld,ram_en,ir_ld,ir_en,a_ld,a_en,b_ld,alu_en,alu_sub,out_ld}
  localparam logic [11:0] PC_INC  = 12'b1000_0000_0000;
  localparam logic [11:0] PC_EN   = 12'b0100_0000_0000;
  localparam logic [11:0] MAR_LD  = 12'b0010_0000_0000;
  localparam logic [11:0] RAM_EN  = 12'b0001_0000_0000;
  localparam logic [11:0] IR_LD   = 12'b0000_1000_0000;
  localparam logic [11:0] IR_EN   = 12'b0000_0100_0000;
  localparam logic [11:0] A_LD    = 12'b0000_0010_0000;
  localparam logic [11:0] A_EN    = 12'b0000_0001_0000;
  localparam logic [11:0] B_LD    = 12'b0000_0000_1000;
  localparam logic [11:0] ALU_EN  = 12'b0000_0000_0100;
  localparam logic [11:0] ALU_SUB = 12'b0000_0000_0010;
  localparam logic [11:0] OUT_LD  = 12'b0000_0000_0001;

  typedef struct {
    logic [11:0] ctrl;
    logic        halt;
    logic [5:0]  ts;
    logic [7:0]  cnt;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  int         m_t;
  logic [7:0] m_cnt;
  logic       m_halt;

  // Hand-written T-state tables, one row per instruction class.
  function automatic logic [11:0] ctrl_for(input int t, input logic [3:0] op, input logic h);
    logic [11:0] w;
    w = '0;
    if (!h) begin
      case (t)
        1: w = PC_EN | MAR_LD;
        2: w = PC_INC;
        3: w = RAM_EN | IR_LD;
        4: case (op)
             4'h0, 4'h1, 4'h2: w = IR_EN | MAR_LD;
             4'hE:             w = A_EN | OUT_LD;
             default:          w = '0;
           endcase
        5: case (op)
             4'h0:    w = RAM_EN | A_LD;
             4'h1:    w = RAM_EN | B_LD;
             4'h2:    w = RAM_EN | B_LD | ALU_SUB;
             default: w = '0;
           endcase
        6: case (op)
             4'h1:    w = ALU_EN | A_LD;
             4'h2:    w = ALU_EN | A_LD | ALU_SUB;
             default: w = '0;
           endcase
        default: w = '0;
      endcase
    end
    return w;
  endfunction

  function automatic logic [5:0] onehot(input int t);
    logic [5:0] r;
    r = 6'b000001;
    return r << (t - 1);
  endfunction

  task automatic push_exp(input string tag, input logic [11:0] ctrl, input logic h,
                          input logic [5:0] ts, input logic [7:0] cnt);
    exp_t e;
    e.ctrl = ctrl;
    e.halt = h;
    e.ts   = ts;
    e.cnt  = cnt;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // Called just after a posedge: drive opcode, queue the expectation, run one clock.
  task automatic step(input string tag, input logic [3:0] op);
    bus.opcode = op;
    push_exp(tag, ctrl_for(m_t, op, m_halt), m_halt || (m_t == 4 && op == 4'hF),
             onehot(m_t), m_cnt);
    @(posedge clk);
    #1;
    if (!m_halt) begin
      if (m_t == 4 && op == 4'hF) m_halt = 1'b1;
      else if (m_t == 6) begin
        m_t   = 1;
        m_cnt = m_cnt + 8'd1;
      end else m_t = m_t + 1;
    end
  endtask

  // Opcode is scrambled during T1/T2 to show fetch ignores it.
  task automatic run_instr(input string tag, input logic [3:0] op);
    for (int i = 0; i < 6; i++) begin
      if (m_t <= 2 && !m_halt) step(tag, 4'($urandom_range(15, 0)));
      else step(tag, op);
    end
  endtask

  task automatic do_reset(input string tag);
    clr_n  = 1'b0;
    m_t    = 1;
    m_cnt  = 8'd0;
    m_halt = 1'b0;
    push_exp(tag, 12'h000, 1'b0, 6'b000001, 8'd0);
    @(posedge clk);
    #1;
    push_exp(tag, 12'h000, 1'b0, 6'b000001, 8'd0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  // Monitor: bus exclusivity every cycle, plus one queued expectation per cycle.
  initial begin
    exp_t        e;
    logic [11:0] got;
    forever begin
      @(negedge clk);
      n_vec++;
      if ($countones({bus.pc_en, bus.ram_en, bus.ir_en, bus.a_en, bus.alu_en}) > 1) begin
        n_fail++;
        $display("FAIL bus_excl t=%0t drivers pc/ram/ir/a/alu=%b required at most one", $time,
                 {bus.pc_en, bus.ram_en, bus.ir_en, bus.a_en, bus.alu_en});
      end
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {bus.pc_inc, bus.pc_en, bus.mar_ld, bus.ram_en, bus.ir_ld, bus.ir_en,
               bus.a_ld, bus.a_en, bus.b_ld, bus.alu_en, bus.alu_sub, bus.out_ld};
        n_vec++;
        if (got !== e.ctrl || bus.halt !== e.halt || bus.t_state !== e.ts ||
            bus.instr_count !== e.cnt) begin
          n_fail++;
          $display("FAIL %s t=%0t ctrl=%b halt=%b ts=%b cnt=%h required ctrl=%b halt=%b ts=%b cnt=%h",
                   e.tag, $time, got, bus.halt, bus.t_state, bus.instr_count,
                   e.ctrl, e.halt, e.ts, e.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t bench did not complete", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_n      = 1'b0;
    bus.opcode = 4'h0;
    m_t = 1; m_cnt = 8'd0; m_halt = 1'b0;
    @(posedge clk);
    #1;

    do_reset("reset");
    run_instr("lda", 4'h0);
    step("lda_after_t1", 4'h0);
    for (int i = 0; i < 5; i++) step("lda_fill", 4'h0);
    run_instr("sub", 4'h2);
    run_instr("add", 4'h1);

    do_reset("reset_out");
    run_instr("out", 4'hE);
    run_instr("hlt", 4'hF);
    repeat (20) step("halted", 4'h0);

    do_reset("reset_add");
    run_instr("lda2", 4'h0);
    for (int i = 0; i < 4; i++) step("add_pre", 4'h1);
    bus.opcode = 4'h1;
    do_reset("reset_mid_t5");
    step("post_reset_t1", 4'h1);
    for (int i = 0; i < 5; i++) step("post_reset", 4'h1);

    do_reset("reset_nop");
    for (int n = 0; n < 256; n++) run_instr("nop", 4'h7);
    step("nop_wrap", 4'h7);
    for (int i = 0; i < 5; i++) step("nop_wrap_fill", 4'h7);

    // Corrupt the ring to a two-hot value; it must recover to T1.
    force dut.state_q = 6'b000011;
    push_exp("illegal_state", 12'h000, 1'b0, 6'b000011, m_cnt);
    @(negedge clk);
    #1;
    release dut.state_q;
    @(posedge clk);
    #1;
    m_t = 1;
    step("illegal_recover", 4'h0);
    step("illegal_recover_t2", 4'h0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain pending=%0d required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sap_ctrl_seq.md
Name: sap_ctrl_seq

Overview:
- Controller-sequencer for the SAP computer. It drives the ld/en/clr control inputs of the PC, MAR, RAM, IR, A, B, ALU and output registers that share the 8-bit bus.
- A 6-state ring counter runs fetch (T1-T3) and execute (T4-T6). The control word is decoded from the current T-state and the IR opcode.
- Guarantees a single bus driver per cycle and latches HLT.

Parameters:
- OPC_LDA, 4'h0, load A from memory
- OPC_ADD, 4'h1, A <= A + mem
- OPC_SUB, 4'h2, A <= A - mem
- OPC_OUT, 4'hE, output register <= A
- OPC_HLT, 4'hF, stop sequencing

Ports:
- clk  in  1  system clock; all state updates on posedge
- clr_n  in  1  asynchronous active-low reset
- opcode  in  4  IR upper nibble; must be stable from end of T3 to end of T6
- pc_inc  out  1  program counter increment
- pc_en  out  1  PC drives bus
- mar_ld  out  1  MAR loads from bus
- ram_en  out  1  RAM drives bus
- ir_ld  out  1  IR loads from bus
- ir_en  out  1  IR operand nibble drives bus
- a_ld  out  1  A loads from bus
- a_en  out  1  A drives bus
- b_ld  out  1  B loads from bus
- alu_en  out  1  ALU drives bus
- alu_sub  out  1  ALU subtract select (0 = add)
- out_ld  out  1  output register loads from bus
- halt  out  1  halted flag
- t_state  out  6  one-hot ring state; bit0 = T1
- instr_count  out  8  completed-instruction count

Behaviour:
- Reset (clr_n = 0, asynchronous):
  - t_state = 6'b000001 (T1); halted flag = 0; instr_count = 0.
  - All control outputs decode to 0 except those for T1, and those are gated off while clr_n = 0. Every output is therefore 0 during reset apart from t_state.
  - Leaving reset is synchronous: the first posedge with clr_n = 1 executes T1.
- Ring advance:
  - T1 -> T2 -> ... -> T6 -> T1 on each posedge while not halted.
  - t_state is always exactly one-hot.
  - An illegal t_state value (e.g. from an SEU) returns to T1 on the next posedge.
- Control outputs:
  - Combinational from registered t_state, opcode and halted. No further latency.
  - Target registers sample on the posedge that ends the state.
- Fetch, identical for every opcode:
  - T1: pc_en, mar_ld.
  - T2: pc_inc.
  - T3: ram_en, ir_ld.
- Execute:
  - LDA: T4 ir_en, mar_ld; T5 ram_en, a_ld; T6 none.
  - ADD: T4 ir_en, mar_ld; T5 ram_en, b_ld; T6 alu_en, a_ld.
  - SUB: as ADD, with alu_sub = 1 in T5 and T6.
  - OUT: T4 a_en, out_ld; T5 none; T6 none.
  - HLT: T4 sets the halted flag on the posedge ending T4.
  - Any other opcode: T4-T6 none (NOP); the count still increments.
- Bus exclusivity:
  - At most one of pc_en, ram_en, ir_en, a_en, alu_en is 1 in any cycle.
  - The bench asserts this every cycle.
- Halt:
  - halt = 1 during T4 of HLT and thereafter.
  - Once halted, t_state freezes at T4 and all other control outputs are 0.
  - Only clr_n = 0 clears halt.
  - HLT does not increment instr_count.
- instr_count:
  - Increments on the posedge ending T6.
  - Wraps from 8'hFF to 8'h00.
- Reset mid-instruction: instruction aborted immediately; no partial ld pulse after clr_n falls; sequencing restarts at T1.
- Opcode sampling: opcode changes during T1-T3 have no effect on outputs in those states, since fetch is opcode-independent.

Test Plan:
- Reset, then 6 clocks with opcode = 4'h0 (LDA) -> per-cycle control words match the T1..T6 LDA table; instr_count = 1; t_state back to 6'b000001.
- SUB (4'h2) -> alu_sub = 1 only in T5 and T6; alu_en = 1 only in T6; a_ld = 1 only in T6. Repeat with ADD (4'h1) -> alu_sub never 1.
- OUT then HLT (4'hE, 4'hF) -> out_ld with a_en in T4 of OUT. halt rises in HLT's T4 and stays high for 20 further clocks; t_state = 6'b001000; all other outputs 0; instr_count = 1.
- Assert clr_n = 0 mid-T5 of ADD -> outputs drop asynchronously before the next edge; t_state = T1; instr_count = 0. After release, the next posedge executes T1 (pc_en = mar_ld = 1).
- Run 256 NOP instructions (opcode 4'h7) from reset -> instr_count wraps to 8'h00; the bus-exclusivity assertion never fires.
- Force t_state to 6'b000011 via the bench -> next posedge t_state = 6'b000001.
